alu_issue_stage: RTL and testbench

ID/EX boundary of the core pipeline and the stage directly upstream of the ALU. It accepts decoded instructions from decode, resolves operand forwarding from EX/MEM and MEM/WB, and selects ALU operands (register, PC or immediate). It generates the 4-bit ALU control code and holds the result in a one-entry valid/ready pipeline register whose outputs drive the ALU inputs directly.

---
 rtl/riscv_pkg.sv | 68 ++++++
 rtl/alu_ctrl_decode.sv | 93 +++++++++
 rtl/alu_issue_stage.sv | 151 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riscv_pkg                                                    |
// | Description : Shared opcodes, ALU control codes and operand/forwarding     |
// |               selector types for the issue stage.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package riscv_pkg;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] c_F3_ADD_SUB = 3'b000;
    localparam logic [2:0] c_F3_SLL     = 3'b001;
    localparam logic [2:0] c_F3_SLT     = 3'b010;
    localparam logic [2:0] c_F3_XOR     = 3'b100;

    typedef enum logic [3:0] {
        ALU_PASS = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_XOR  = 4'b0110
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        INP1_RS1  = 2'd0,
        INP1_PC   = 2'd1,
        INP1_ZERO = 2'd2
    } inp1_sel_e;

    typedef enum logic {
        INP2_RS2 = 1'b0,
        INP2_IMM = 1'b1
    } inp2_sel_e;

    // EX/MEM is the younger producer, so it wins over MEM/WB.
    // The x0 case is handled by the caller.
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] rs,
        input logic       exm_v,
        input logic [4:0] exm_rd,
        input logic       wb_v,
        input logic [4:0] wb_rd
    );
        if (exm_v && (exm_rd == rs))
            return FWD_EXM;
        else if (wb_v && (wb_rd == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_ctrl_decode                                              |
// | Description : Combinational opcode/funct3/funct7[5] decode into ALU        |
// |               control, operand selectors, shift flag and illegal flag.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_ctrl_decode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output alu_op_e    alu_control,
    output logic       illegal,
    output inp1_sel_e  inp1_sel,
    output inp2_sel_e  inp2_sel,
    output logic       shift
);

    // Decode; any unsupported combination falls back to PASS with illegal set.
    always_comb begin
        alu_control = ALU_PASS;
        illegal     = 1'b0;
        inp1_sel    = INP1_RS1;
        inp2_sel    = INP2_RS2;
        shift       = 1'b0;

        case (opcode)
            c_OPC_OP: begin
                case (funct3)
                    c_F3_ADD_SUB: alu_control = funct7_5 ? ALU_SUB : ALU_ADD;
                    c_F3_SLL: begin
                        if (funct7_5) illegal = 1'b1;
                        else begin
                            alu_control = ALU_SLL;
                            shift       = 1'b1;
                        end
                    end
                    c_F3_SLT: begin
                        if (funct7_5) illegal = 1'b1;
                        else          alu_control = ALU_SLT;
                    end
                    c_F3_XOR: begin
                        if (funct7_5) illegal = 1'b1;
                        else          alu_control = ALU_XOR;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            c_OPC_OP_IMM: begin
                inp2_sel = INP2_IMM;
                // funct7[5] is an immediate bit except on the shift encoding.
                case (funct3)
                    c_F3_ADD_SUB: alu_control = ALU_ADD;
                    c_F3_SLL: begin
                        if (funct7_5) illegal = 1'b1;
                        else begin
                            alu_control = ALU_SLL;
                            shift       = 1'b1;
                        end
                    end
                    c_F3_SLT: alu_control = ALU_SLT;
                    c_F3_XOR: alu_control = ALU_XOR;
                    default:  illegal = 1'b1;
                endcase
            end
            c_OPC_LOAD, c_OPC_STORE, c_OPC_JALR: begin
                inp2_sel    = INP2_IMM;
                alu_control = ALU_ADD;
            end
            c_OPC_LUI: begin
                inp1_sel    = INP1_ZERO;
                inp2_sel    = INP2_IMM;
                alu_control = ALU_ADD;
            end
            c_OPC_AUIPC: begin
                inp1_sel    = INP1_PC;
                inp2_sel    = INP2_IMM;
                alu_control = ALU_ADD;
            end
            c_OPC_BRANCH: alu_control = ALU_SUB;
            default:      illegal = 1'b1;
        endcase

        if (illegal) begin
            alu_control = ALU_PASS;
            shift       = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_issue_stage                                              |
// | Description : ID/EX boundary: operand forwarding, ALU operand selection,   |
// |               ALU control generation and a one-entry valid/ready register. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_issue_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [4:0]      id_rd_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [6:0]      id_opcode,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_5,
    input  logic            exm_fwd_valid,
    input  logic [4:0]      exm_rd_addr,
    input  logic [XLEN-1:0] exm_rd_data,
    input  logic            wb_fwd_valid,
    input  logic [4:0]      wb_rd_addr,
    input  logic [XLEN-1:0] wb_rd_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] alu_inp1,
    output logic [XLEN-1:0] alu_inp2,
    output logic [3:0]      alu_control,
    output logic [4:0]      ex_rd_addr,
    output logic [XLEN-1:0] ex_pc,
    output logic            ex_illegal
);

    alu_op_e         w_alu_op;
    logic            w_illegal;
    inp1_sel_e       w_inp1_sel;
    inp2_sel_e       w_inp2_sel;
    logic            w_shift;
    logic            w_accept;
    logic [XLEN-1:0] w_rs1_fwd;
    logic [XLEN-1:0] w_rs2_fwd;
    logic [XLEN-1:0] w_inp1;
    logic [XLEN-1:0] w_inp2_raw;
    logic [XLEN-1:0] w_inp2;

    logic            r_ex_valid;
    logic            r_ex_illegal;
    logic [3:0]      r_alu_control;
    logic [XLEN-1:0] r_alu_inp1;
    logic [XLEN-1:0] r_alu_inp2;
    logic [4:0]      r_ex_rd_addr;
    logic [XLEN-1:0] r_ex_pc;

    alu_ctrl_decode u_decode (
        .opcode      (id_opcode),
        .funct3      (id_funct3),
        .funct7_5    (id_funct7_5),
        .alu_control (w_alu_op),
        .illegal     (w_illegal),
        .inp1_sel    (w_inp1_sel),
        .inp2_sel    (w_inp2_sel),
        .shift       (w_shift)
    );

    // No skid buffer: ready whenever the slot is empty or drains this cycle.
    assign id_ready = !r_ex_valid || ex_ready;
    assign w_accept = id_valid && id_ready;

    // Source operand forwarding; x0 always reads as zero.
    always_comb begin
        w_rs1_fwd = id_rs1_data;
        w_rs2_fwd = id_rs2_data;
        if (id_rs1_addr == 5'd0) begin
            w_rs1_fwd = '0;
        end else begin
            case (fwd_select(id_rs1_addr, exm_fwd_valid, exm_rd_addr, wb_fwd_valid, wb_rd_addr))
                FWD_EXM: w_rs1_fwd = exm_rd_data;
                FWD_WB:  w_rs1_fwd = wb_rd_data;
                default: w_rs1_fwd = id_rs1_data;
            endcase
        end
        if (id_rs2_addr == 5'd0) begin
            w_rs2_fwd = '0;
        end else begin
            case (fwd_select(id_rs2_addr, exm_fwd_valid, exm_rd_addr, wb_fwd_valid, wb_rd_addr))
                FWD_EXM: w_rs2_fwd = exm_rd_data;
                FWD_WB:  w_rs2_fwd = wb_rd_data;
                default: w_rs2_fwd = id_rs2_data;
            endcase
        end
    end

    // ALU operand selection; shifts only see the low five bits of the amount.
    always_comb begin
        case (w_inp1_sel)
            INP1_PC:   w_inp1 = id_pc;
            INP1_ZERO: w_inp1 = '0;
            default:   w_inp1 = w_rs1_fwd;
        endcase
        w_inp2_raw = (w_inp2_sel == INP2_IMM) ? id_imm : w_rs2_fwd;
        w_inp2     = w_shift ? {{(XLEN-5){1'b0}}, w_inp2_raw[4:0]} : w_inp2_raw;
    end

    // Pipeline register: data loads on accept only; valid follows flush/accept/drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_illegal  <= 1'b0;
            r_alu_control <= 4'b0000;
            r_alu_inp1    <= '0;
            r_alu_inp2    <= '0;
            r_ex_rd_addr  <= 5'd0;
            r_ex_pc       <= '0;
        end else begin
            if (w_accept) begin
                r_ex_illegal  <= w_illegal;
                r_alu_control <= w_alu_op;
                r_alu_inp1    <= w_inp1;
                r_alu_inp2    <= w_inp2;
                r_ex_rd_addr  <= id_rd_addr;
                r_ex_pc       <= id_pc;
            end
            if (flush)
                r_ex_valid <= 1'b0;
            else if (w_accept)
                r_ex_valid <= 1'b1;
            else if (ex_ready)
                r_ex_valid <= 1'b0;
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_illegal  = r_ex_illegal;
    assign alu_control = r_alu_control;
    assign alu_inp1    = r_alu_inp1;
    assign alu_inp2    = r_alu_inp2;
    assign ex_rd_addr  = r_ex_rd_addr;
    assign ex_pc       = r_ex_pc;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_issue_stage                                           |
// | Description : Directed self-checking bench for alu_issue_stage.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_issue_stage;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [4:0]      id_rs1_addr;
    logic [4:0]      id_rs2_addr;
    logic [4:0]      id_rd_addr;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [6:0]      id_opcode;
    logic [2:0]      id_funct3;
    logic            id_funct7_5;
    logic            exm_fwd_valid;
    logic [4:0]      exm_rd_addr;
    logic [XLEN-1:0] exm_rd_data;
    logic            wb_fwd_valid;
    logic [4:0]      wb_rd_addr;
    logic [XLEN-1:0] wb_rd_data;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] alu_inp1;
    logic [XLEN-1:0] alu_inp2;
    logic [3:0]      alu_control;
    logic [4:0]      ex_rd_addr;
    logic [XLEN-1:0] ex_pc;
    logic            ex_illegal;

    int n_checks = 0;
    int n_pass   = 0;

    alu_issue_stage #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_pc         (id_pc),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs2_addr   (id_rs2_addr),
        .id_rd_addr    (id_rd_addr),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_opcode     (id_opcode),
        .id_funct3     (id_funct3),
        .id_funct7_5   (id_funct7_5),
        .exm_fwd_valid (exm_fwd_valid),
        .exm_rd_addr   (exm_rd_addr),
        .exm_rd_data   (exm_rd_data),
        .wb_fwd_valid  (wb_fwd_valid),
        .wb_rd_addr    (wb_rd_addr),
        .wb_rd_data    (wb_rd_data),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .alu_inp1      (alu_inp1),
        .alu_inp2      (alu_inp2),
        .alu_control   (alu_control),
        .ex_rd_addr    (ex_rd_addr),
        .ex_pc         (ex_pc),
        .ex_illegal    (ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                         input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [31:0] pc);
        id_valid    = 1'b1;
        id_opcode   = op;
        id_funct3   = f3;
        id_funct7_5 = f75;
        id_rs1_addr = rs1;
        id_rs1_data = d1;
        id_rs2_addr = rs2;
        id_rs2_data = d2;
        id_imm      = imm;
        id_pc       = pc;
        id_rd_addr  = 5'd9;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        id_pc = '0; id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
        id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_opcode = '0; id_funct3 = '0; id_funct7_5 = 1'b0;
        exm_fwd_valid = 1'b0; exm_rd_addr = '0; exm_rd_data = '0;
        wb_fwd_valid = 1'b0; wb_rd_addr = '0; wb_rd_data = '0;

        // Reset values
        #2;
        check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("rst_illegal", {31'b0, ex_illegal}, 32'd0);
        check("rst_ctrl", {28'b0, alu_control}, 32'd0);
        check("rst_inp1", alu_inp1, 32'd0);
        check("rst_inp2", alu_inp2, 32'd0);
        check("rst_pc", ex_pc, 32'd0);
        check("rst_rd", {27'b0, ex_rd_addr}, 32'd0);
        #5 rst_n = 1'b1;
        step();
        check("idle_id_ready", {31'b0, id_ready}, 32'd1);

        // ADD x1=5, x2=7
        drive(7'b0110011, 3'b000, 1'b0, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 32'h40);
        step();
        check("add_valid", {31'b0, ex_valid}, 32'd1);
        check("add_inp1", alu_inp1, 32'd5);
        check("add_inp2", alu_inp2, 32'd7);
        check("add_ctrl", {28'b0, alu_control}, 32'b0010);
        check("add_rd", {27'b0, ex_rd_addr}, 32'd9);
        check("add_pc", ex_pc, 32'h40);

        // Forwarding priority on rs1=x3
        drive(7'b0110011, 3'b000, 1'b0, 5'd3, 32'h11, 5'd2, 32'd7, 32'h0, 32'h44);
        exm_fwd_valid = 1'b1; exm_rd_addr = 5'd3; exm_rd_data = 32'hAA;
        wb_fwd_valid  = 1'b1; wb_rd_addr  = 5'd3; wb_rd_data  = 32'hBB;
        step();
        check("fwd_exm", alu_inp1, 32'hAA);
        check("fwd_exm_rs2_rf", alu_inp2, 32'd7);
        exm_fwd_valid = 1'b0;
        step();
        check("fwd_wb", alu_inp1, 32'hBB);
        wb_fwd_valid = 1'b0;
        step();
        check("fwd_rf", alu_inp1, 32'h11);
        exm_fwd_valid = 1'b1; exm_rd_addr = 5'd0;
        wb_fwd_valid  = 1'b1; wb_rd_addr  = 5'd0;
        drive(7'b0110011, 3'b000, 1'b0, 5'd0, 32'h55, 5'd2, 32'd7, 32'h0, 32'h48);
        step();
        check("fwd_x0", alu_inp1, 32'd0);
        exm_fwd_valid = 1'b0; wb_fwd_valid = 1'b0;
        exm_rd_addr = 5'd2; wb_rd_addr = 5'd2;
        wb_fwd_valid = 1'b1; wb_rd_data = 32'hCC;
        step();
        check("fwd_wb_rs2", alu_inp2, 32'hCC);
        wb_fwd_valid = 1'b0;

        // Shift masking, OP and OP-IMM
        drive(7'b0110011, 3'b001, 1'b0, 5'd1, 32'd5, 5'd5, 32'hFFFF_FF23, 32'h0, 32'h4C);
        step();
        check("sll_inp2", alu_inp2, 32'h3);
        check("sll_ctrl", {28'b0, alu_control}, 32'b0001);
        drive(7'b0010011, 3'b001, 1'b0, 5'd1, 32'd5, 5'd0, 32'h0, 32'h0000_0425, 32'h50);
        step();
        check("slli_inp2", alu_inp2, 32'h5);
        check("slli_ctrl", {28'b0, alu_control}, 32'b0001);
        drive(7'b0010011, 3'b001, 1'b1, 5'd1, 32'd5, 5'd0, 32'h0, 32'h0000_0405, 32'h54);
        step();
        check("slli_f7_illegal", {31'b0, ex_illegal}, 32'd1);
        check("slli_f7_ctrl", {28'b0, alu_control}, 32'b0000);

        // SUB, SLT, XOR, illegal encodings
        drive(7'b0110011, 3'b000, 1'b1, 5'd1, 32'd9, 5'd2, 32'd4, 32'h0, 32'h58);
        step();
        check("sub_ctrl", {28'b0, alu_control}, 32'b0100);
        check("sub_legal", {31'b0, ex_illegal}, 32'd0);
        drive(7'b0110011, 3'b010, 1'b0, 5'd1, 32'd9, 5'd2, 32'd4, 32'h0, 32'h5C);
        step();
        check("slt_ctrl", {28'b0, alu_control}, 32'b0101);
        drive(7'b0010011, 3'b100, 1'b1, 5'd1, 32'd9, 5'd0, 32'd0, 32'hFFFF_FC00, 32'h60);
        step();
        check("xori_ctrl", {28'b0, alu_control}, 32'b0110);
        check("xori_inp2", alu_inp2, 32'hFFFF_FC00);
        check("xori_legal", {31'b0, ex_illegal}, 32'd0);
        drive(7'b0110011, 3'b100, 1'b1, 5'd1, 32'd9, 5'd2, 32'd4, 32'h0, 32'h64);
        step();
        check("xor_f7_illegal", {31'b0, ex_illegal}, 32'd1);
        drive(7'b1110011, 3'b000, 1'b0, 5'd1, 32'd9, 5'd2, 32'd4, 32'h0, 32'h68);
        step();
        check("sys_ctrl", {28'b0, alu_control}, 32'b0000);
        check("sys_illegal", {31'b0, ex_illegal}, 32'd1);
        check("sys_valid", {31'b0, ex_valid}, 32'd1);

        // Operand selection: LUI, AUIPC, BRANCH, LOAD
        drive(7'b0110111, 3'b000, 1'b0, 5'd1, 32'd9, 5'd2, 32'd4, 32'h1234_5000, 32'h6C);
        step();
        check("lui_inp1", alu_inp1, 32'd0);
        check("lui_inp2", alu_inp2, 32'h1234_5000);
        check("lui_ctrl", {28'b0, alu_control}, 32'b0010);
        drive(7'b0010111, 3'b000, 1'b0, 5'd1, 32'd9, 5'd2, 32'd4, 32'h0000_2000, 32'h100);
        step();
        check("auipc_inp1", alu_inp1, 32'h100);
        check("auipc_inp2", alu_inp2, 32'h2000);
        drive(7'b1100011, 3'b000, 1'b0, 5'd1, 32'd9, 5'd2, 32'd4, 32'h10, 32'h104);
        step();
        check("br_ctrl", {28'b0, alu_control}, 32'b0100);
        check("br_inp2", alu_inp2, 32'd4);
        drive(7'b0000011, 3'b010, 1'b0, 5'd1, 32'h1000, 5'd2, 32'd4, 32'h8, 32'h108);
        step();
        check("ld_inp2", alu_inp2, 32'h8);
        check("ld_ctrl", {28'b0, alu_control}, 32'b0010);

        // Stall, then flush
        drive(7'b0110011, 3'b000, 1'b0, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 32'h200);
        step();
        ex_ready = 1'b0;
        drive(7'b0110011, 3'b100, 1'b0, 5'd1, 32'hDEAD, 5'd2, 32'hBEEF, 32'h0, 32'h204);
        #1;
        check("stall_id_ready", {31'b0, id_ready}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_valid", {31'b0, ex_valid}, 32'd1);
            check("stall_inp1", alu_inp1, 32'd5);
            check("stall_ctrl", {28'b0, alu_control}, 32'b0010);
            check("stall_pc", ex_pc, 32'h200);
            check("stall_id_ready", {31'b0, id_ready}, 32'd0);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid", {31'b0, ex_valid}, 32'd0);
        check("flush_id_ready", {31'b0, id_ready}, 32'd1);
        id_valid = 1'b0;
        step();
        drive(7'b0110011, 3'b000, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 32'h0, 32'h208);
        flush = 1'b1;
        step();
        flush = 1'b0;
        id_valid = 1'b0;
        check("flush_accept_valid", {31'b0, ex_valid}, 32'd0);

        // Asynchronous reset while holding a valid instruction
        drive(7'b0110011, 3'b000, 1'b1, 5'd1, 32'd30, 5'd2, 32'd10, 32'h0, 32'h300);
        step();
        id_valid = 1'b0;
        check("pre_rst_valid", {31'b0, ex_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'b0, ex_valid}, 32'd0);
        check("arst_ctrl", {28'b0, alu_control}, 32'd0);
        check("arst_inp1", alu_inp1, 32'd0);
        check("arst_inp2", alu_inp2, 32'd0);
        check("arst_pc", ex_pc, 32'd0);
        #2 rst_n = 1'b1;
        step();
        check("post_rst_valid", {31'b0, ex_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
